ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//  Fetch stage that sits between the PC register and instruction memory/decode.
//  Each cycle it issues the current pc to imem and tags the request with its pc.
//  It buffers in-order responses in a DEPTH-entry queue and hands {pc, inst} to decode.
//  It drives stall back to the PC unit and discards in-flight fetches when a jump occurs.
// PARAMETERS
//  XLEN   64  address/pc width
//  DEPTH  4   queue entries (power of 2, >=2); caps requests in flight plus buffered
// PORTS
//  clk             in   1     clock, rising edge
//  rst             in   1     asynchronous, active-low reset
//  pc              in   XLEN  current fetch pc from PC unit
//  jump            in   1     redirect/flush, same signal as PC unit JUMP
//  stall           out  1     to PC unit: hold pc this cycle
//  imem_req_valid  out  1     fetch request valid
//  imem_req_addr   out  XLEN  fetch address (= pc)
//  imem_req_ready  in   1     imem accepts request
//  imem_resp_valid in   1     in-order response valid (latency >=1, no backpressure)
//  imem_resp_data  in   32    instruction word
//  id_valid        out  1     decode entry valid
//  id_pc           out  XLEN  pc of head entry
//  id_inst         out  32    instruction of head entry
//  id_ready        in   1     decode consumes head
// BEHAVIOUR
//  - Reset (rst=0, async): head/tail/fill pointers=0, count=0, drop_cnt=0, all entries invalid;
//    imem_req_valid=0, id_valid=0, id_pc=0, id_inst=0, stall=1 while rst asserted.
//  - Queue entries: {pc, inst, filled}. Slot allocated at tail on request accept;
//    fill pointer marks the oldest unfilled slot; head delivered once filled.
//  - credit_ok = (count + drop_cnt) < DEPTH.
//  - imem_req_valid = rst & !jump & credit_ok; imem_req_addr = pc (combinational).
//  - accept = imem_req_valid & imem_req_ready -> alloc tail with pc, tail++, count++.
//  - stall = !accept (combinational). The PC unit advances to pc+4 only on accept.
//    jump overrides stall in the PC unit.
//  - Response: if drop_cnt>0, discard and drop_cnt--; else write inst to fill slot,
//    set filled, fill++. A response with no unfilled slot and drop_cnt=0 is ignored.
//  - Decode: id_valid = head.filled & !jump; id_pc/id_inst = head fields.
//    Pop on id_valid & id_ready: head++, count--. Alloc and pop in the same cycle: count unchanged.
//  - Latency: request accepted in cycle N; response in cycle >=N+1 is written at that edge.
//    id_valid is asserted in the following cycle, so minimum pc->id_valid is 2 cycles.
//  - Flush (jump=1): no request and no pop that cycle. At the edge, all entries invalid,
//    pointers=0, count=0. drop_cnt += unfilled, where unfilled = allocated-but-unfilled slots
//    minus 1 if imem_resp_valid that cycle; such a response is consumed from drop_cnt or
//    from a slot and is lost either way. The next cycle fetches the JUMP_PC target.
//  - Back-to-back jumps accumulate correctly into drop_cnt. drop_cnt width = log2(DEPTH)+1.
//  - Pointers wrap modulo DEPTH. count==DEPTH is full, so credit_ok=0.
//  - Reset mid-operation clears everything immediately. Outstanding imem responses after
//    reset are the system's responsibility; imem is reset together with this block.
// TESTING
//  1. imem 1-cycle latency, id_ready=1, pc 0x0,0x4,0x8 -> id_pc 0x0,0x4,0x8 in order,
//     from cycle 2; stall=0 steady.
//  2. id_ready=0, DEPTH=4 -> 4 accepts, then stall=1 and imem_req_valid=0.
//     id_ready=1 -> 0x0 popped, fetch resumes at 0x10.
//  3. imem latency 3, 2 requests in flight, jump to 0x100 -> next 2 responses dropped;
//     first id_pc=0x100.
//  4. jump in the same cycle as imem_resp_valid and id_ready -> id_valid=0 that cycle,
//     drop_cnt excludes that response, no stale pc is delivered.
//  5. imem_req_ready=0 for 3 cycles -> stall=1, imem_req_addr stable at pc; accept on release.
//  6. rst low with 3 entries buffered -> id_valid and imem_req_valid=0 before next clk edge;
//     fetch restarts at 0x0.

Source files
------------

// File: rtl/ifetch_queue.sv
// Fetch queue: issues pc to imem, tags each request with its pc, and buffers in-order responses for decode.
// Latency: 2 cycles minimum from pc accept to id_valid. The response is written at the edge; the entry is visible the next cycle.
// Backpressure: stall holds the pc until imem accepts it. Requests stop when buffered, in-flight and to-be-dropped fetches reach DEPTH.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   pc, jump, stall               PC unit interface (jump flushes the queue; stall holds pc)
//   imem_req_valid/ready/addr     fetch request to instruction memory
//   imem_resp_valid/data          in-order responses (latency >= 1, no backpressure)
//   id_valid/ready, id_pc/inst    head entry handed to decode
module ifetch_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            jump,
    output logic            stall,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_inst,
    input  logic            id_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] P_ONE   = PW'(1);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);

    logic [XLEN-1:0]  ent_pc   [DEPTH];
    logic [31:0]      ent_inst [DEPTH];
    logic [DEPTH-1:0] ent_filled;

    logic [PW-1:0] head, tail, fill;
    // pend counts allocated-but-unfilled slots. It is kept explicitly because
    // tail == fill is ambiguous when every slot is outstanding.
    logic [CW-1:0] count, pend, drop_cnt;

    logic        credit_ok, accept, pop, resp_drop, resp_fill;
    logic [CW:0] occupancy;

    // Fetches still owed to a flushed stream hold credit until they return.
    // Otherwise responses to the new stream could outrun the slots.
    assign occupancy = {1'b0, count} + {1'b0, drop_cnt};
    assign credit_ok = occupancy < DEPTH_L;

    assign imem_req_valid = rst & ~jump & credit_ok;
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid & imem_req_ready;
    assign stall          = ~accept;

    assign id_valid = ent_filled[head] & ~jump;
    assign id_pc    = ent_pc[head];
    assign id_inst  = ent_inst[head];
    assign pop      = id_valid & id_ready;

    // Responses are matched to requests by order only. The responses owed to
    // flushed fetches come back first, so they are discarded first.
    assign resp_drop = imem_resp_valid & (drop_cnt != '0);
    assign resp_fill = imem_resp_valid & (drop_cnt == '0) & (pend != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            fill       <= '0;
            count      <= '0;
            pend       <= '0;
            drop_cnt   <= '0;
            ent_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc[i]   <= '0;
                ent_inst[i] <= '0;
            end
        end else if (jump) begin
            head       <= '0;
            tail       <= '0;
            fill       <= '0;
            count      <= '0;
            pend       <= '0;
            ent_filled <= '0;
            // A response arriving now is consumed either from drop_cnt or from a slot.
            // The slot is flushed anyway. Either way, that response is no longer owed.
            drop_cnt   <= drop_cnt + pend - CW'(resp_drop | resp_fill);
        end else begin
            if (accept) begin
                ent_pc[tail] <= pc;
                tail         <= tail + P_ONE;
            end
            // The fill slot is never the head slot while the head is filled.
            // Setting the fill slot and clearing the head slot therefore never collide.
            if (resp_fill) begin
                ent_inst[fill]   <= imem_resp_data;
                ent_filled[fill] <= 1'b1;
                fill             <= fill + P_ONE;
            end
            if (pop) begin
                ent_filled[head] <= 1'b0;
                head             <= head + P_ONE;
            end
            count <= count + CW'(accept) - CW'(pop);
            pend  <= pend + CW'(accept) - CW'(resp_fill);
            if (resp_drop) begin
                drop_cnt <= drop_cnt - C_ONE;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc;
    logic            jump;
    logic            stall;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_inst;
    logic            id_ready;

    ifetch_queue #(.XLEN(XLEN), .DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .jump            (jump),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .id_ready        (id_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int lat;
    int cyc_n;
    logic [XLEN-1:0] jpc;
    logic [XLEN-1:0] req_q[$];
    int              due_q[$];
    logic [XLEN-1:0] got_pc[$];

    logic            s_stall, s_rv, s_idv;
    logic [XLEN-1:0] s_addr, s_idpc;
    logic [31:0]     s_inst;

    function automatic logic [31:0] inst_of(input logic [XLEN-1:0] a);
        return a[31:0] ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle.
    // Sample the DUT mid-cycle, then advance the PC unit and imem models at the edge.
    task automatic cyc();
        logic acc;
        @(negedge clk);
        s_stall = stall;
        s_rv    = imem_req_valid;
        s_addr  = imem_req_addr;
        s_idv   = id_valid;
        s_idpc  = id_pc;
        s_inst  = id_inst;
        acc     = imem_req_valid & imem_req_ready;
        if (acc) begin
            req_q.push_back(imem_req_addr);
            due_q.push_back(cyc_n + lat);
        end
        if (id_valid && id_ready) got_pc.push_back(id_pc);
        @(posedge clk);
        #1;
        cyc_n++;
        if (jump) pc = jpc;
        else if (acc) pc = pc + 64'd4;
        if (due_q.size() > 0 && due_q[0] <= cyc_n) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = inst_of(req_q[0]);
            void'(req_q.pop_front());
            void'(due_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    endtask

    // Assert reset and check that the outputs clear before any clock edge.
    // The imem model is reset with the block.
    task automatic do_reset(input string tag);
        rst             = 1'b0;
        jump            = 1'b0;
        pc              = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        req_q.delete();
        due_q.delete();
        got_pc.delete();
        #2;
        chk({tag, "_rst_idv"},   64'(id_valid),       64'd0);
        chk({tag, "_rst_rv"},    64'(imem_req_valid), 64'd0);
        chk({tag, "_rst_stall"}, 64'(stall),          64'd1);
        chk({tag, "_rst_idpc"},  id_pc,               64'd0);
        chk({tag, "_rst_inst"},  64'(id_inst),        64'd0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        cyc_n = 0;
    endtask

    initial begin
        rst            = 1'b1;
        pc             = '0;
        jump           = 1'b0;
        jpc            = '0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        lat            = 1;
        cyc_n          = 0;
        #1;
        do_reset("init");

        // Streaming with 1-cycle imem: in order, first delivery in cycle 2, never stalls.
        lat = 1; id_ready = 1'b1; imem_req_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk($sformatf("t1_stall_c%0d", c), 64'(s_stall), 64'd0);
            chk($sformatf("t1_addr_c%0d", c),  s_addr,       64'(4 * c));
            chk($sformatf("t1_idv_c%0d", c),   64'(s_idv),   64'(c >= 2));
            if (c >= 2) begin
                chk($sformatf("t1_idpc_c%0d", c), s_idpc,       64'(4 * (c - 2)));
                chk($sformatf("t1_inst_c%0d", c), 64'(s_inst),  64'(inst_of(64'(4 * (c - 2)))));
            end
        end

        // Decode blocked: four accepts fill the queue, then stall until a pop.
        do_reset("t2");
        lat = 1; id_ready = 1'b0; imem_req_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk($sformatf("t2_stall_c%0d", c), 64'(s_stall), 64'd0);
            chk($sformatf("t2_addr_c%0d", c),  s_addr,       64'(4 * c));
        end
        cyc();
        chk("t2_full_stall", 64'(s_stall), 64'd1);
        chk("t2_full_rv",    64'(s_rv),    64'd0);
        chk("t2_full_idv",   64'(s_idv),   64'd1);
        cyc();
        chk("t2_hold_addr",  s_addr,       64'h10);
        chk("t2_hold_rv",    64'(s_rv),    64'd0);
        id_ready = 1'b1;
        cyc();
        chk("t2_pop_idpc",   s_idpc,       64'h0);
        chk("t2_pop_rv",     64'(s_rv),    64'd0);
        cyc();
        chk("t2_resume_rv",   64'(s_rv),    64'd1);
        chk("t2_resume_addr", s_addr,       64'h10);
        chk("t2_resume_idpc", s_idpc,       64'h4);

        // Latency 3, two fetches in flight at the jump: both responses are dropped.
        do_reset("t3");
        lat = 3; id_ready = 1'b1; imem_req_ready = 1'b1;
        cyc();
        cyc();
        jump = 1'b1; jpc = 64'h100;
        cyc();
        chk("t3_jump_rv",  64'(s_rv),  64'd0);
        chk("t3_jump_idv", 64'(s_idv), 64'd0);
        jump = 1'b0;
        cyc();
        chk("t3_tgt_addr", s_addr,     64'h100);
        chk("t3_tgt_rv",   64'(s_rv),  64'd1);
        for (int c = 4; c < 7; c++) begin
            cyc();
            chk($sformatf("t3_drop_idv_c%0d", c), 64'(s_idv), 64'd0);
        end
        cyc();
        chk("t3_first_idv",  64'(s_idv),  64'd1);
        chk("t3_first_idpc", s_idpc,      64'h100);
        chk("t3_first_inst", 64'(s_inst), 64'(inst_of(64'h100)));
        cyc();
        chk("t3_second_idpc", s_idpc,     64'h104);

        // Jump coincides with a response and a ready decode.
        // No pop occurs, and the response is not counted as owed.
        do_reset("t4");
        lat = 1; id_ready = 1'b1; imem_req_ready = 1'b1;
        cyc();
        cyc();
        jump = 1'b1; jpc = 64'h200;
        cyc();
        chk("t4_jump_idv", 64'(s_idv), 64'd0);
        chk("t4_jump_rv",  64'(s_rv),  64'd0);
        jump = 1'b0;
        cyc();
        chk("t4_tgt_idv",  64'(s_idv), 64'd0);
        chk("t4_tgt_addr", s_addr,     64'h200);
        chk("t4_tgt_rv",   64'(s_rv),  64'd1);
        cyc();
        chk("t4_wait_idv", 64'(s_idv), 64'd0);
        cyc();
        chk("t4_first_idv",  64'(s_idv), 64'd1);
        chk("t4_first_idpc", s_idpc,     64'h200);
        chk("t4_delivered_n", 64'(got_pc.size()), 64'd1);
        if (got_pc.size() > 0) chk("t4_delivered_pc", got_pc[0], 64'h200);

        // imem not ready for 3 cycles: pc held, accepted on release.
        do_reset("t5");
        lat = 1; id_ready = 1'b1; imem_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk($sformatf("t5_stall_c%0d", c), 64'(s_stall), 64'd1);
            chk($sformatf("t5_rv_c%0d", c),    64'(s_rv),    64'd1);
            chk($sformatf("t5_addr_c%0d", c),  s_addr,       64'h0);
        end
        imem_req_ready = 1'b1;
        cyc();
        chk("t5_rel_stall", 64'(s_stall), 64'd0);
        chk("t5_rel_addr",  s_addr,       64'h0);
        cyc();
        chk("t5_next_addr", s_addr,       64'h4);
        cyc();
        chk("t5_idv",  64'(s_idv), 64'd1);
        chk("t5_idpc", s_idpc,     64'h0);

        // Reset with entries buffered: outputs clear immediately, fetch restarts at 0.
        do_reset("t6a");
        lat = 1; id_ready = 1'b0; imem_req_ready = 1'b1;
        repeat (4) cyc();
        chk("t6_buf_idv",  64'(s_idv), 64'd1);
        chk("t6_buf_idpc", s_idpc,     64'h0);
        do_reset("t6b");
        id_ready = 1'b1;
        cyc();
        chk("t6_restart_rv",   64'(s_rv), 64'd1);
        chk("t6_restart_addr", s_addr,    64'h0);
        cyc();
        cyc();
        chk("t6_restart_idv",  64'(s_idv), 64'd1);
        chk("t6_restart_idpc", s_idpc,     64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
